// File: rtl/mem_arbiter.sv
// Round-robin arbiter for fetch and load/store ports onto one memory port. One transaction is outstanding at a time.
// Accept at t, mem request from t+1, response at t+2 or later. Downstream stalls hold the request stable, and a silent memory times out.
module mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [XLEN-1:0]   ifu_req_addr_i,
  output logic              ifu_resp_valid_o,
  output logic [XLEN-1:0]   ifu_resp_data_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [XLEN-1:0]   lsu_req_addr_i,
  input  logic              lsu_req_wen_i,
  input  logic [XLEN-1:0]   lsu_req_wdata_i,
  input  logic [XLEN/8-1:0] lsu_req_wmask_i,
  output logic              lsu_resp_valid_o,
  output logic [XLEN-1:0]   lsu_resp_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_req_addr_o,
  output logic              mem_req_wen_o,
  output logic [XLEN-1:0]   mem_req_wdata_o,
  output logic [XLEN/8-1:0] mem_req_wmask_o,
  input  logic              mem_resp_valid_i,
  input  logic [XLEN-1:0]   mem_resp_data_i,
  output logic              busy_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              last_lsu_q;   // 0 = IFU granted last, so LSU wins the first tie
  logic              owner_lsu_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic              wen_q;
  logic [XLEN/8-1:0] wmask_q;
  logic [7:0]        cnt_q;

  logic grant_ifu, grant_lsu, resp_hit, to_hit;

  // Reset masks every combinational decision so the outputs are quiet during reset.
  always_comb begin
    grant_ifu = (state_q == IDLE) && !rst_i && ifu_req_valid_i && (!lsu_req_valid_i || last_lsu_q);
    grant_lsu = (state_q == IDLE) && !rst_i && lsu_req_valid_i && (!ifu_req_valid_i || !last_lsu_q);
    resp_hit  = (state_q == RESP) && !rst_i && mem_resp_valid_i;
    to_hit    = (state_q == RESP) && !rst_i && !mem_resp_valid_i && (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_lsu_q  <= 1'b0;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (grant_ifu || grant_lsu) begin
        owner_lsu_q <= grant_lsu;
        last_lsu_q  <= grant_lsu;
        addr_q      <= grant_lsu ? lsu_req_addr_i : ifu_req_addr_i;
        wen_q       <= grant_lsu & lsu_req_wen_i;
        wdata_q     <= grant_lsu ? lsu_req_wdata_i : '0;
        wmask_q     <= grant_lsu ? lsu_req_wmask_i : '0;
      end
      // Saturate rather than wrap; the timeout compare fires before saturation.
      if (state_q == REQ)
        cnt_q <= '0;
      else if (state_q == RESP && !mem_resp_valid_i && cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ifu || grant_lsu) state_d = REQ;
      REQ:     if (mem_req_ready_i) state_d = RESP;
      RESP:    if (resp_hit || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready_o  = grant_ifu;
    lsu_req_ready_o  = grant_lsu;
    mem_req_valid_o  = 1'b0;
    mem_req_addr_o   = '0;
    mem_req_wen_o    = 1'b0;
    mem_req_wdata_o  = '0;
    mem_req_wmask_o  = '0;
    ifu_resp_valid_o = 1'b0;
    ifu_resp_data_o  = '0;
    lsu_resp_valid_o = 1'b0;
    lsu_resp_data_o  = '0;
    busy_o           = !rst_i && (state_q != IDLE);
    timeout_o        = to_hit;
    if (state_q == REQ && !rst_i) begin
      mem_req_valid_o = 1'b1;
      mem_req_addr_o  = addr_q;
      mem_req_wen_o   = wen_q;
      mem_req_wdata_o = wdata_q;
      mem_req_wmask_o = wmask_q;
    end
    if (resp_hit || to_hit) begin
      if (owner_lsu_q) begin
        lsu_resp_valid_o = 1'b1;
        lsu_resp_data_o  = resp_hit ? mem_resp_data_i : '0;
      end else begin
        ifu_resp_valid_o = 1'b1;
        ifu_resp_data_o  = resp_hit ? mem_resp_data_i : '0;
      end
    end
  end

endmodule
